// File: rtl/mode_datetime_set_p.sv
// Date-set mode: shadow date edited field by field, COMMIT pulsed on exit.
// Optional MODE_SET_AUTOREPEAT_EN adds hold-to-repeat on inc/dec.
module mode_datetime_set_p #(
  parameter int          YEAR_DIGITS  = 4,
  parameter logic [23:0] YEAR_RESET   = 24'h2020,
  parameter logic [3:0]  MODE_CODE    = 4'b0011,
  parameter int          REPEAT_DELAY = 50,
  parameter int          REPEAT_RATE  = 10,
  localparam int         YW = 4 * YEAR_DIGITS,
  localparam int         CW = $clog2(YEAR_DIGITS + 2)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [3:0]    MODE,
  input  logic [3:0]    NUM_LEVEL,
  input  logic [YW-1:0] CUR_YEAR,
  input  logic [6:0]    CUR_MONTH,
  input  logic [6:0]    CUR_DAY,
  output logic [CW-1:0] CURSOR,
  output logic [YW-1:0] YEAR,
  output logic [6:0]    MONTH,
  output logic [6:0]    DAY,
  output logic          EDITING,
  output logic          COMMIT
);

  if (YEAR_DIGITS < 3 || YEAR_DIGITS > 6 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad
    $error("mode_datetime_set_p: bad parameters");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EDIT = 1'b1;
  localparam logic [CW-1:0] CMAX = CW'(YEAR_DIGITS + 1);

  function automatic logic div4(input logic [3:0] t,
                                input logic [3:0] o);
    if (t[0]) return (o == 4'd2) || (o == 4'd6);
    return (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
  endfunction

  // Only the low four digits take part in the leap rule.
  function automatic logic is_leap(input logic [YW-1:0] y);
    logic [23:0] p;
    p = 24'(y);
    if (p[7:0] != 8'h00) return div4(p[7:4], p[3:0]);
    return div4(p[15:12], p[11:8]);
  endfunction

  function automatic logic [6:0] dim(input logic [6:0] m,
                                     input logic lp);
    unique case (1'b1)
      m == 7'd2: return lp ? 7'd29 : 7'd28;
      m == 7'd4 || m == 7'd6 ||
      m == 7'd9 || m == 7'd11: return 7'd30;
      default: return 7'd31;
    endcase
  endfunction

  logic [0:0]    state;
  logic [3:0]    prev, rise;
  logic          act, single, sdec, rfire;
  logic          inc_go, dec_go, cur_next, cur_prev;
  logic [6:0]    d_dim, n_dim, e_dim, e_month, e_day;
  logic [6:0]    n_month, n_day;
  logic [YW-1:0] n_year;
  logic [CW-1:0] n_cursor;

  assign rise     = NUM_LEVEL & ~prev;
  assign act      = (state == EDIT) && (MODE == MODE_CODE);
  assign single   = NUM_LEVEL[0] ^ NUM_LEVEL[1];
  assign sdec     = NUM_LEVEL[1];
  assign cur_next = act & rise[2] & ~NUM_LEVEL[3];
  assign cur_prev = act & rise[3] & ~NUM_LEVEL[2];
  assign inc_go   = act & single & ~sdec & (rise[0] | rfire);
  assign dec_go   = act & single & sdec & (rise[1] | rfire);
  assign EDITING  = (state == EDIT);

`ifdef MODE_SET_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt, rtgt;
  logic          rphase, rdec, cur_edge, s_edge;

  assign cur_edge = act & (rise[2] | rise[3]);
  assign s_edge   = single & (sdec ? rise[1] : rise[0]);
  assign rtgt     = rphase ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
  assign rfire    = (rcnt != '0) && (rcnt == rtgt) && (rdec == sdec);

  // rcnt counts cycles since the last step; zero means idle.
  always_ff @(posedge CLK) begin
    if (RESET || !act || cur_edge || !single) begin
      rcnt   <= '0;
      rphase <= 1'b0;
      rdec   <= 1'b0;
    end else if (s_edge) begin
      rcnt   <= RW'(1);
      rphase <= 1'b0;
      rdec   <= sdec;
    end else if (rcnt != '0 && rdec == sdec) begin
      if (rfire) begin
        rcnt   <= RW'(1);
        rphase <= 1'b1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
    end else begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end
  end
`else
  assign rfire = 1'b0;
`endif

  always_comb begin
    e_month = (CUR_MONTH >= 7'd1 && CUR_MONTH <= 7'd12) ?
              CUR_MONTH : 7'd1;
    e_dim   = dim(e_month, is_leap(CUR_YEAR));
    e_day   = (CUR_DAY == 7'd0) ? 7'd1 :
              (CUR_DAY > e_dim) ? e_dim : CUR_DAY;
  end

  always_comb begin
    d_dim    = dim(MONTH, is_leap(YEAR));
    n_year   = YEAR;
    n_month  = MONTH;
    n_day    = DAY;
    n_cursor = CURSOR;
    if (inc_go | dec_go) begin
      unique case (1'b1)
        CURSOR == '0:
          n_day = inc_go ?
            ((DAY >= d_dim) ? 7'd1 : DAY + 7'd1) :
            ((DAY <= 7'd1) ? d_dim : DAY - 7'd1);
        CURSOR == CW'(1):
          n_month = inc_go ?
            ((MONTH >= 7'd12) ? 7'd1 : MONTH + 7'd1) :
            ((MONTH <= 7'd1) ? 7'd12 : MONTH - 7'd1);
        default: begin
          for (int k = 0; k < YEAR_DIGITS; k++) begin
            if (CURSOR == CW'(k + 2)) begin
              if (inc_go)
                n_year[4*k+:4] = (YEAR[4*k+:4] >= 4'd9) ?
                  4'd0 : YEAR[4*k+:4] + 4'd1;
              else
                n_year[4*k+:4] = (YEAR[4*k+:4] == 4'd0 ||
                  YEAR[4*k+:4] > 4'd9) ?
                  4'd9 : YEAR[4*k+:4] - 4'd1;
            end
          end
        end
      endcase
    end
    n_dim = dim(n_month, is_leap(n_year));
    if (n_day > n_dim) n_day = n_dim;
    if (cur_next)
      n_cursor = (CURSOR >= CMAX) ? '0 : CURSOR + CW'(1);
    else if (cur_prev)
      n_cursor = (CURSOR == '0) ? CMAX : CURSOR - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      prev   <= 4'd0;
      CURSOR <= '0;
      YEAR   <= YEAR_RESET[YW-1:0];
      MONTH  <= 7'd1;
      DAY    <= 7'd1;
      COMMIT <= 1'b0;
    end else begin
      prev   <= NUM_LEVEL;
      COMMIT <= 1'b0;
      if (state == IDLE) begin
        if (MODE == MODE_CODE) begin
          state  <= EDIT;
          CURSOR <= '0;
          YEAR   <= CUR_YEAR;
          MONTH  <= e_month;
          DAY    <= e_day;
        end
      end else if (MODE != MODE_CODE) begin
        state  <= IDLE;
        COMMIT <= 1'b1;
      end else begin
        CURSOR <= n_cursor;
        YEAR   <= n_year;
        MONTH  <= n_month;
        DAY    <= n_day;
      end
    end
  end

endmodule

// File: tb/tb_mode_datetime_set_p.sv
// Bench for mode_datetime_set_p: directed scenarios plus random edits
// checked against a calendar-level model.
module tb_mode_datetime_set_p;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  MODE, NUM_LEVEL;
  logic [15:0] CUR_YEAR;
  logic [6:0]  CUR_MONTH, CUR_DAY;
  logic [2:0]  CURSOR;
  logic [15:0] YEAR;
  logic [6:0]  MONTH, DAY;
  logic        EDITING, COMMIT;

  int errors = 0;
  int checks = 0;

  logic [15:0] my;
  int mm, md, mc;

  mode_datetime_set_p dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE), .NUM_LEVEL(NUM_LEVEL),
    .CUR_YEAR(CUR_YEAR), .CUR_MONTH(CUR_MONTH), .CUR_DAY(CUR_DAY),
    .CURSOR(CURSOR), .YEAR(YEAR), .MONTH(MONTH), .DAY(DAY),
    .EDITING(EDITING), .COMMIT(COMMIT)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic int yint(logic [15:0] y);
    return int'(y[15:12]) * 1000 + int'(y[11:8]) * 100 +
           int'(y[7:4]) * 10 + int'(y[3:0]);
  endfunction

  function automatic int mdim(int mo, logic [15:0] y);
    int v;
    bit lp;
    v  = yint(y);
    lp = ((v % 4 == 0) && (v % 100 != 0)) || (v % 400 == 0);
    if (mo == 2) return lp ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  task automatic mstep(input bit dn);
    int k, dg, dm;
    dm = mdim(mm, my);
    if (mc == 0) begin
      md = dn ? ((md == 1) ? dm : md - 1) : ((md == dm) ? 1 : md + 1);
    end else if (mc == 1) begin
      mm = dn ? ((mm == 1) ? 12 : mm - 1) : ((mm == 12) ? 1 : mm + 1);
    end else begin
      k  = mc - 2;
      dg = int'(my[4*k+:4]);
      dg = dn ? (dg + 9) % 10 : (dg + 1) % 10;
      my[4*k+:4] = 4'(dg);
    end
    dm = mdim(mm, my);
    if (md > dm) md = dm;
  endtask

  task automatic press(input logic [3:0] m);
    NUM_LEVEL = m;
    tick;
    NUM_LEVEL = 4'd0;
    tick;
    if (m == 4'd1) mstep(1'b0);
    else if (m == 4'd2) mstep(1'b1);
    else if (m == 4'd4) mc = (mc + 1) % 6;
    else if (m == 4'd8) mc = (mc + 5) % 6;
  endtask

  task automatic enter(input logic [15:0] y, input int mo, input int d);
    int dm;
    if (EDITING) begin
      MODE = 4'd0;
      tick;
      tick;
    end
    CUR_YEAR  = y;
    CUR_MONTH = 7'(mo);
    CUR_DAY   = 7'(d);
    MODE      = 4'b0011;
    tick;
    my = y;
    mm = (mo >= 1 && mo <= 12) ? mo : 1;
    dm = mdim(mm, my);
    md = (d == 0) ? 1 : (d > dm) ? dm : d;
    mc = 0;
  endtask

  task automatic test_reset;
    RESET = 1'b1; MODE = 4'd0; NUM_LEVEL = 4'd0;
    CUR_YEAR = 16'h0; CUR_MONTH = 7'd0; CUR_DAY = 7'd0;
    tick;
    tick;
    RESET = 1'b0;
    if ({CURSOR, YEAR, MONTH, DAY, EDITING, COMMIT} !==
        {3'd0, 16'h2020, 7'd1, 7'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: c=%0d y=%h m=%0d d=%0d ed=%b cm=%b want 0 2020 1 1 0 0",
               CURSOR, YEAR, MONTH, DAY, EDITING, COMMIT);
    end
    checks++;
  endtask

  task automatic test_entry;
    enter(16'h2024, 2, 29);
    if ({EDITING, CURSOR, YEAR, MONTH, DAY} !==
        {1'b1, 3'd0, 16'h2024, 7'd2, 7'd29}) begin
      errors++;
      $display("FAIL entry: ed=%b c=%0d y=%h m=%0d d=%0d want 1 0 2024 2 29",
               EDITING, CURSOR, YEAR, MONTH, DAY);
    end
    checks++;
  endtask

  task automatic test_leap_year;
    press(4'd4);
    press(4'd4);
    press(4'd1);
    if ({CURSOR, YEAR, DAY} !== {3'd2, 16'h2025, 7'd28}) begin
      errors++;
      $display("FAIL leap_inc: c=%0d y=%h d=%0d want 2 2025 28",
               CURSOR, YEAR, DAY);
    end
    checks++;
    press(4'd2);
    if ({YEAR, DAY} !== {16'h2024, 7'd28}) begin
      errors++;
      $display("FAIL leap_dec: y=%h d=%0d want 2024 28", YEAR, DAY);
    end
    checks++;
  endtask

  task automatic test_century;
    enter(16'h1900, 2, 28);
    press(4'd1);
    if (DAY !== 7'd1) begin
      errors++;
      $display("FAIL y1900: d=%0d want 1", DAY);
    end
    checks++;
    enter(16'h2000, 2, 28);
    press(4'd1);
    if (DAY !== 7'd29) begin
      errors++;
      $display("FAIL y2000: d=%0d want 29", DAY);
    end
    checks++;
  endtask

  task automatic test_cursor;
    enter(16'h2023, 4, 1);
    press(4'd2);
    if ({CURSOR, DAY} !== {3'd0, 7'd30}) begin
      errors++;
      $display("FAIL day_wrap: c=%0d d=%0d want 0 30", CURSOR, DAY);
    end
    checks++;
    press(4'd8);
    if (CURSOR !== 3'd5) begin
      errors++;
      $display("FAIL cur_prev_wrap: c=%0d want 5", CURSOR);
    end
    checks++;
    press(4'd4);
    if (CURSOR !== 3'd0) begin
      errors++;
      $display("FAIL cur_next_wrap: c=%0d want 0", CURSOR);
    end
    checks++;
    press(4'd4);
    press(4'd4);
    press(4'd4);
    press(4'b1100);
    if (CURSOR !== 3'd3) begin
      errors++;
      $display("FAIL cur_both: c=%0d want 3", CURSOR);
    end
    checks++;
    press(4'b0011);
    if (YEAR !== 16'h2023) begin
      errors++;
      $display("FAIL step_both: y=%h want 2023", YEAR);
    end
    checks++;
  endtask

  task automatic test_repeat;
    int n, want;
    enter(16'h2023, 1, 15);
    press(4'd4);
    NUM_LEVEL = 4'd1;
    repeat (200) tick;
    NUM_LEVEL = 4'd0;
    tick;
    n = 1;
`ifdef MODE_SET_AUTOREPEAT_EN
    for (int c = 2; c <= 200; c++)
      if (c - 1 >= 50 && (c - 1 - 50) % 10 == 0) n++;
`endif
    want = (n % 12) + 1;
    if ({MONTH, DAY} !== {7'(want), 7'd15}) begin
      errors++;
      $display("FAIL repeat: m=%0d d=%0d want %0d 15", MONTH, DAY, want);
    end
    checks++;
    mm = want;
    mc = 1;
  endtask

  task automatic test_random;
    logic [15:0] y;
    logic [3:0] ops [6];
    ops = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12};
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 4; k++) y[4*k+:4] = 4'($urandom_range(0, 9));
      enter(y, int'($urandom_range(0, 15)), int'($urandom_range(0, 40)));
      if ({CURSOR, YEAR, MONTH, DAY} !== {3'(mc), my, 7'(mm), 7'(md)}) begin
        errors++;
        $display("FAIL rnd_entry: c=%0d y=%h m=%0d d=%0d want %0d %h %0d %0d",
                 CURSOR, YEAR, MONTH, DAY, mc, my, mm, md);
      end
      checks++;
      for (int i = 0; i < 15; i++) begin
        press(ops[$urandom_range(0, 5)]);
        if ({CURSOR, YEAR, MONTH, DAY} !== {3'(mc), my, 7'(mm), 7'(md)}) begin
          errors++;
          $display("FAIL rnd_step: c=%0d y=%h m=%0d d=%0d want %0d %h %0d %0d",
                   CURSOR, YEAR, MONTH, DAY, mc, my, mm, md);
        end
        checks++;
      end
    end
  endtask

  task automatic test_commit;
    MODE = 4'd0;
    tick;
    if ({COMMIT, EDITING} !== 2'b10) begin
      errors++;
      $display("FAIL commit_pulse: cm=%b ed=%b want 1 0", COMMIT, EDITING);
    end
    checks++;
    tick;
    if (COMMIT !== 1'b0) begin
      errors++;
      $display("FAIL commit_len: cm=%b want 0", COMMIT);
    end
    checks++;
    NUM_LEVEL = 4'd1;
    tick;
    tick;
    NUM_LEVEL = 4'd0;
    if ({YEAR, MONTH, DAY} !== {my, 7'(mm), 7'(md)}) begin
      errors++;
      $display("FAIL idle_hold: y=%h m=%0d d=%0d want %h %0d %0d",
               YEAR, MONTH, DAY, my, mm, md);
    end
    checks++;
  endtask

  task automatic test_reset_mid_edit;
    int seen;
    enter(16'h2031, 7, 20);
    press(4'd1);
    RESET = 1'b1;
    MODE  = 4'd0;
    tick;
    RESET = 1'b0;
    seen  = int'(COMMIT);
    repeat (3) begin
      tick;
      seen += int'(COMMIT);
    end
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_commit: commit cycles=%0d want 0", seen);
    end
    checks++;
    if ({EDITING, CURSOR, YEAR, MONTH, DAY} !==
        {1'b0, 3'd0, 16'h2020, 7'd1, 7'd1}) begin
      errors++;
      $display("FAIL reset_vals: ed=%b c=%0d y=%h m=%0d d=%0d want 0 0 2020 1 1",
               EDITING, CURSOR, YEAR, MONTH, DAY);
    end
    checks++;
  endtask

  initial begin
    test_reset;
    test_entry;
    test_leap_year;
    test_century;
    test_cursor;
    test_repeat;
    test_random;
    test_commit;
    test_reset_mid_edit;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode_datetime_set_p.md
Name: mode_datetime_set_p

Overview:
Parametrised successor to the date-setting mode block of the watch datapath. It keeps a shadow copy of the date, loaded from the running calendar on mode entry, and edits it field by field with the cursor. Day is always clamped to a legal day-of-month, including the leap-year rule. On mode exit it pulses COMMIT so the calendar can take the edited date. It adds configurable year width and hold-to-repeat stepping.

Parameters:
YEAR_DIGITS, 4, number of BCD year digits; legal range 3..6.
YEAR_RESET, 16'h2020, packed BCD year loaded at reset; zero-extended or truncated to 4*YEAR_DIGITS bits.
MODE_CODE, 4'b0011, MODE value that selects this block.
REPEAT_DELAY, 50, cycles a step button is held before auto-repeat begins.
REPEAT_RATE, 10, cycles between auto-repeat steps.

Ports:
CLK  in  1  system clock.
RESET  in  1  synchronous reset, active-high.
MODE  in  4  current watch mode.
NUM_LEVEL  in  4  synchronised, debounced button levels: [0]=inc, [1]=dec, [2]=cursor next, [3]=cursor prev.
CUR_YEAR  in  4*YEAR_DIGITS  running calendar year, packed BCD, digit 0 = ones.
CUR_MONTH  in  7  running month, binary.
CUR_DAY  in  7  running day, binary.
CURSOR  out  CW=$clog2(YEAR_DIGITS+2)  selected field: 0=day, 1=month, 2+k=year digit k.
YEAR  out  4*YEAR_DIGITS  edited year, packed BCD.
MONTH  out  7  edited month, binary, 1..12.
DAY  out  7  edited day, binary, 1..dim.
EDITING  out  1  high while the FSM is in EDIT.
COMMIT  out  1  one-cycle pulse on exit from EDIT.

Behaviour:
- Clock is CLK. RESET is synchronous and active-high. It overrides all other inputs.
- Reset values: CURSOR=0, YEAR=YEAR_RESET, MONTH=1, DAY=1, EDITING=0, COMMIT=0, FSM=IDLE. The button history register and the repeat counter are cleared.
- FSM states are IDLE and EDIT.
- IDLE to EDIT: taken in the cycle where MODE==MODE_CODE.
  - In that cycle the block loads YEAR<=CUR_YEAR and sets CURSOR<=0.
  - MONTH<=CUR_MONTH if CUR_MONTH is in 1..12; otherwise MONTH<=1.
  - DAY<=CUR_DAY, clamped to the range 1..dim(loaded month, loaded year).
  - All buttons are ignored in this cycle.
  - EDITING is high from the next cycle.
- EDIT to IDLE: taken in the cycle where MODE!=MODE_CODE.
  - COMMIT=1 for exactly the next cycle.
  - YEAR, MONTH and DAY hold their values in IDLE.
- RESET during EDIT: the block goes straight to reset values and no COMMIT is generated.
- Edge detection: each button's previous level is registered. A step fires on a 0-to-1 transition. Buttons act only in EDIT.
- Cursor:
  - A rising edge on [2] alone increments CURSOR; it wraps from YEAR_DIGITS+1 to 0.
  - A rising edge on [3] alone decrements CURSOR; it wraps from 0 to YEAR_DIGITS+1.
  - If [2] and [3] are both high, the cursor does not move.
- Value step: an inc or dec step is applied to the field selected by CURSOR before any same-cycle cursor update.
  - Day: 1..dim; inc from dim gives 1, dec from 1 gives dim.
  - Month: 1..12 with wrap. After a month step, DAY<=min(DAY, dim(new month)) in the same cycle.
  - Year digit k: 0..9 with wrap; there is no carry into adjacent digits. DAY is re-clamped in the same cycle, which covers 29 Feb becoming 28 Feb.
  - If [0] and [1] are both high, no step happens and the repeat counter is cleared.
- dim table: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; month 2 gives 29 if leap, otherwise 28.
- leap rule, with the year divided into two-digit pairs:
  - lo = year digits 1:0, hi = year digits 3:2. Digit 3 reads as 0 when YEAR_DIGITS==3.
  - A pair is divisible by 4 when (tens even and ones in {0,4,8}) or (tens odd and ones in {2,6}).
  - If lo!=00: leap = lo divisible by 4.
  - If lo==00: leap = hi divisible by 4.
- Auto-repeat applies to inc and dec only:
  - The counter starts on the step edge.
  - A further step fires once REPEAT_DELAY cycles have elapsed since the edge, then every REPEAT_RATE cycles while the same single button stays high.
  - Releasing the button, pressing the other button, a cursor edge, or leaving EDIT clears the counter.
- All arithmetic is registered. Outputs change one cycle after the triggering edge.

Optional Feature:
MODE_SET_AUTOREPEAT_EN:
- Defined: hold-to-repeat behaves as specified above.
- Undefined: the repeat counter and its logic are absent, and inc/dec step only on rising edges. REPEAT_DELAY and REPEAT_RATE are unused.

Test Plan:
- Reset, then MODE=0011 with CUR=2024/02/29 -> after 1 cycle: EDITING=1, YEAR=16'h2024, MONTH=2, DAY=29, CURSOR=0.
- In EDIT on 2024/02/29, CURSOR=2 (year ones), one inc edge -> YEAR=16'h2025, DAY=28. A dec edge after that -> YEAR=16'h2024, DAY stays 28.
- Year 1900 and year 2000, MONTH=2, DAY=28, CURSOR=0, inc -> 1900: DAY=1. 2000: DAY=29.
- CURSOR=0, dec edge -> CURSOR stays 0, DAY=dim. CURSOR=5 with next edge -> CURSOR=0. Prev and next held together -> CURSOR unchanged.
- With the macro defined, inc held 200 cycles on CURSOR=1 from MONTH=1 -> steps at cycles 1, 51, 61, ..., 191; MONTH advances by 1+15=16 with wrap, ending at 5. With the macro undefined -> MONTH=2.
- MODE changes away from 0011 -> COMMIT high for exactly 1 cycle, values held. RESET asserted mid-edit -> no COMMIT, YEAR=16'h2020, MONTH=1, DAY=1.
